// File: rtl/ro_pkg.sv
// Shared definitions for the readout frame serializer.
//   ro_state_e  : serializer FSM states
//   RO_SYNC_PAT : default frame sync header pattern
package ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } ro_state_e;

    localparam logic [7:0] RO_SYNC_PAT = 8'hA5;

endpackage

// File: rtl/ro_shift_reg.sv
// Parametrised load/shift register used as the counts shadow and serializer.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears contents)
//   load       : capture din (optionally shifted once in the same edge)
//   shift      : advance the register by one position
//   dir        : 0 = shift toward bit 0 (head is bit 0), 1 = toward MSB (head is MSB)
//   din        : parallel load value
//   head       : bit currently at the output end of the register
module ro_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         dir,
    input  logic [W-1:0] din,
    output logic         head
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    function automatic logic [W-1:0] shift1(input logic [W-1:0] v, input logic d);
        shift1 = d ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
    endfunction

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            // Load+shift lets the first bit leave on the load edge itself.
            sr_d = shift ? shift1(din, dir) : din;
        end else if (shift) begin
            sr_d = shift1(sr_q, dir);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign head = dir ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/ro_frame_serializer.sv
// Readout frame serializer: sends an optional sync header followed by
// NUM_CH counter values, one bit per data_clk cycle, from a snapshot of
// counts taken when the frame is accepted.
// Ports:
//   data_clk    : single clock, rising edge
//   reset       : synchronous active-high reset, aborts any frame
//   start       : request one frame (sampled only when idle)
//   continuous  : at frame end, start the next frame back-to-back
//   counts      : channel k at [k*CNT_W +: CNT_W]
//   data_out    : registered serial bit (0 when bit_valid is low)
//   frame_start : one-cycle pulse with the first bit of a frame
//   bit_valid   : data_out carries a frame bit
//   ch_sel      : channel being sent (0 during the header)
//   busy        : frame in progress
//   done        : one-cycle pulse on the cycle after the last frame bit
module ro_frame_serializer
    import ro_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int SYNC_W    = 8,
    parameter logic [((SYNC_W > 0) ? SYNC_W : 1)-1:0] SYNC_PAT = RO_SYNC_PAT,
    parameter int MSB_FIRST = 0
) (
    input  logic                       data_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       continuous,
    input  logic [NUM_CH*CNT_W-1:0]    counts,
    output logic                       data_out,
    output logic                       frame_start,
    output logic                       bit_valid,
    output logic [$clog2(NUM_CH)-1:0]  ch_sel,
    output logic                       busy,
    output logic                       done
);

    localparam int TOT_W = NUM_CH * CNT_W;
    localparam int CHW   = $clog2(NUM_CH);
    localparam int MAXW  = (SYNC_W > CNT_W) ? SYNC_W : CNT_W;
    localparam int BCW   = ($clog2(MAXW) > 0) ? $clog2(MAXW) : 1;
    localparam int SPW   = (SYNC_W > 0) ? SYNC_W : 1;

    localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_W - 1);
    localparam logic [BCW-1:0] CNT_LAST  = BCW'(CNT_W - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);
    localparam logic           DIR       = (MSB_FIRST != 0);

    ro_state_e        state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CHW-1:0]   ch_sel_q, ch_sel_d;
    logic             data_out_q, data_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;

    logic [TOT_W-1:0] arranged;
    logic             load_head;
    logic             sr_head;
    logic             sr_load;
    logic             sr_shift;
    logic             begin_frame;

    // Header bit at position pos, counted from the MSB of the pattern.
    function automatic logic sync_bit(input logic [BCW-1:0] pos);
        logic [SPW-1:0] t;
        t = SYNC_PAT << pos;
        return t[SPW-1];
    endfunction

    // For MSB-first the channel order is mirrored so a left shift emits
    // ch0 MSB..LSB, then ch1, and so on.
    always_comb begin
        arranged = counts;
        if (MSB_FIRST != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                arranged[(NUM_CH-1-k)*CNT_W +: CNT_W] = counts[k*CNT_W +: CNT_W];
            end
        end
    end

    assign load_head = DIR ? arranged[TOT_W-1] : arranged[0];

    ro_shift_reg #(.W(TOT_W)) u_shadow (
        .clk   (data_clk),
        .reset (reset),
        .load  (sr_load),
        .shift (sr_shift),
        .dir   (DIR),
        .din   (arranged),
        .head  (sr_head)
    );

    // state_q / bit_cnt_q / ch_sel_q describe the bit currently on data_out;
    // the *_d values describe the bit to present after the next edge.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        ch_sel_d      = ch_sel_q;
        data_out_d    = 1'b0;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        begin_frame   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    begin_frame = 1'b1;
                end
            end
            ST_SYNC: begin
                bit_valid_d = 1'b1;
                if (bit_cnt_q == SYNC_LAST) begin
                    state_d    = ST_DATA;
                    bit_cnt_d  = '0;
                    data_out_d = sr_head;
                    sr_shift   = 1'b1;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    data_out_d = sync_bit(bit_cnt_q + 1'b1);
                end
            end
            ST_DATA: begin
                if (bit_cnt_q == CNT_LAST && ch_sel_q == CH_LAST) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    ch_sel_d  = '0;
                    if (continuous) begin
                        begin_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_valid_d = 1'b1;
                    data_out_d  = sr_head;
                    sr_shift    = 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        ch_sel_d  = ch_sel_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New frame: snapshot counts and present its first bit next cycle.
        if (begin_frame) begin
            sr_load       = 1'b1;
            frame_start_d = 1'b1;
            bit_valid_d   = 1'b1;
            bit_cnt_d     = '0;
            ch_sel_d      = '0;
            if (SYNC_W > 0) begin
                state_d    = ST_SYNC;
                data_out_d = sync_bit('0);
            end else begin
                state_d    = ST_DATA;
                data_out_d = load_head;
                sr_shift   = 1'b1;
            end
        end
    end

    always_ff @(posedge data_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            ch_sel_q      <= '0;
            data_out_q    <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            ch_sel_q      <= ch_sel_d;
            data_out_q    <= data_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign data_out    = data_out_q;
    assign frame_start = frame_start_q;
    assign bit_valid   = bit_valid_q;
    assign ch_sel      = ch_sel_q;
    assign busy        = bit_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ro_frame_serializer.sv
// Directed self-checking bench for ro_frame_serializer: default instance
// (4 x 32-bit, A5 header, LSB first) plus a corner instance
// (2 x 8-bit, no header, MSB first).
module tb_ro_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, continuous;
    logic [127:0] counts;
    logic         data_out, frame_start, bit_valid, busy, done;
    logic [1:0]   ch_sel;

    logic         start2, cont2;
    logic [15:0]  counts2;
    logic         d2_out, d2_fs, d2_vld, d2_busy, d2_done;
    logic [0:0]   d2_ch;

    ro_frame_serializer dut (
        .data_clk    (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .counts      (counts),
        .data_out    (data_out),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .ch_sel      (ch_sel),
        .busy        (busy),
        .done        (done)
    );

    ro_frame_serializer #(
        .NUM_CH    (2),
        .CNT_W     (8),
        .SYNC_W    (0),
        .SYNC_PAT  (1'b0),
        .MSB_FIRST (1)
    ) dut2 (
        .data_clk    (clk),
        .reset       (reset),
        .start       (start2),
        .continuous  (cont2),
        .counts      (counts2),
        .data_out    (d2_out),
        .frame_start (d2_fs),
        .bit_valid   (d2_vld),
        .ch_sel      (d2_ch),
        .busy        (d2_busy),
        .done        (d2_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-cycle capture; index c = cycle following the c-th edge of a run.
    logic       dout [0:511];
    logic       vld  [0:511];
    logic       fs   [0:511];
    logic       dn   [0:511];
    logic       bsy  [0:511];
    logic [1:0] chs  [0:511];
    logic       o2   [0:511];
    logic       fs2  [0:511];
    logic       vld2 [0:511];
    logic       dn2  [0:511];

    // mode 0 plain, 1 scramble counts, 2 start pulse at bit 50,
    // 3 reset at bit 70, 4 drop continuous during the third frame
    task automatic run(input int n, input int mode);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            dout[c] = data_out; vld[c] = bit_valid; fs[c] = frame_start;
            dn[c] = done; bsy[c] = busy; chs[c] = ch_sel;
            o2[c] = d2_out; fs2[c] = d2_fs; vld2[c] = d2_vld; dn2[c] = d2_done;
            start  = 1'b0;
            start2 = 1'b0;
            reset  = 1'b0;
            if (mode == 1) counts = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 2 && c == 51) start = 1'b1;
            if (mode == 3 && c == 71) reset = 1'b1;
            if (mode == 4 && c == 300) continuous = 1'b0;
        end
    endtask

    function automatic logic [135:0] exp_frame(input logic [127:0] c);
        logic [7:0]   pat;
        logic [135:0] r;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) r[i] = pat[7-i];
        r[135:8] = c;
        return r;
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [127:0] c);
        logic [135:0] g, e;
        for (int i = 0; i < 136; i++) g[i] = dout[base+i];
        e = exp_frame(c);
        check({tag, "_hdr"}, 64'(g[7:0]), 64'(e[7:0]));
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_ch%0d", tag, k), 64'(g[8+32*k +: 32]), 64'(e[8+32*k +: 32]));
    endtask

    function automatic int cnt_fs(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++) s += int'(fs[i]);
        return s;
    endfunction

    function automatic int cnt_vld(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++) s += int'(vld[i]);
        return s;
    endfunction

    function automatic int cnt_dn(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++) s += int'(dn[i]);
        return s;
    endfunction

    localparam logic [127:0] C1 = {32'h0000_00FF, 32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF};
    localparam logic [127:0] C2 = {32'h0F0F_3C3C, 32'hA5A5_5A5A, 32'h0000_0000, 32'hFFFF_0001};
    localparam logic [127:0] C3 = {32'hCAFE_F00D, 32'h7FFF_FFFE, 32'h1357_9BDF, 32'h2468_ACE0};

    initial begin
        logic [127:0] saved;
        logic [15:0]  e2, g2;

        reset = 1'b1; start = 1'b0; continuous = 1'b0; counts = '0;
        start2 = 1'b0; cont2 = 1'b0; counts2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 64'({data_out, frame_start, bit_valid, busy, done, ch_sel}), 64'd0);
        check("rst_outs2", 64'({d2_out, d2_fs, d2_vld, d2_busy, d2_done, d2_ch}), 64'd0);
        reset = 1'b0;

        // Default frame
        counts = C1; start = 1'b1;
        run(140, 0);
        check_frame("t1", 1, C1);
        check("t1_fs_first", 64'(fs[1]), 64'd1);
        check("t1_fs_count", 64'(cnt_fs(1, 140)), 64'd1);
        check("t1_vld_count", 64'(cnt_vld(1, 136)), 64'd136);
        check("t1_vld_after", 64'(vld[137]), 64'd0);
        check("t1_dout_after", 64'(dout[137]), 64'd0);
        check("t1_done_137", 64'(dn[137]), 64'd1);
        check("t1_done_count", 64'(cnt_dn(1, 140)), 64'd1);
        check("t1_busy_1", 64'(bsy[1]), 64'd1);
        check("t1_busy_136", 64'(bsy[136]), 64'd1);
        check("t1_busy_137", 64'(bsy[137]), 64'd0);
        check("t1_ch_hdr", 64'(chs[8]), 64'd0);
        check("t1_ch_c0", 64'(chs[40]), 64'd0);
        check("t1_ch_c1", 64'(chs[41]), 64'd1);
        check("t1_ch_c3", 64'(chs[136]), 64'd3);
        check("t1_ch_wrap", 64'(chs[137]), 64'd0);

        // Snapshot: counts scrambled every cycle after start
        counts = C2; saved = C2; start = 1'b1;
        run(140, 1);
        check_frame("t2", 1, saved);
        check("t2_done_137", 64'(dn[137]), 64'd1);

        // Start while busy is ignored
        counts = C3; start = 1'b1;
        run(300, 2);
        check_frame("t3", 1, C3);
        check("t3_fs_count", 64'(cnt_fs(1, 300)), 64'd1);
        check("t3_vld_count", 64'(cnt_vld(1, 300)), 64'd136);
        check("t3_done_count", 64'(cnt_dn(1, 300)), 64'd1);

        // Reset mid-frame, then a fresh frame
        counts = C1; start = 1'b1;
        run(80, 3);
        check("t4_mid_vld", 64'(vld[71]), 64'd1);
        check("t4_outs_zero", 64'({dout[72], vld[72], fs[72], bsy[72], dn[72], chs[72]}), 64'd0);
        check("t4_no_done", 64'(cnt_dn(1, 80)), 64'd0);
        start = 1'b1;
        run(140, 0);
        check_frame("t4b", 1, C1);
        check("t4b_done_137", 64'(dn[137]), 64'd1);

        // Continuous: three back-to-back frames
        counts = C3; continuous = 1'b1; start = 1'b1;
        run(420, 4);
        check("t5_vld_run", 64'(cnt_vld(1, 408)), 64'd408);
        check("t5_vld_total", 64'(cnt_vld(1, 420)), 64'd408);
        check("t5_fs_count", 64'(cnt_fs(1, 420)), 64'd3);
        check("t5_fs_done_2", 64'({fs[137], dn[137]}), 64'b11);
        check("t5_fs_done_3", 64'({fs[273], dn[273]}), 64'b11);
        check("t5_end", 64'({fs[409], dn[409], vld[409]}), 64'b010);
        check("t5_done_count", 64'(cnt_dn(1, 420)), 64'd3);
        check_frame("t5f2", 137, C3);
        check_frame("t5f3", 273, C3);

        // Corner instance: 2 x 8 bits, no header, MSB first
        counts2 = 16'h81C3; start2 = 1'b1;
        run(20, 0);
        e2 = 16'b1100_0011_1000_0001;
        for (int i = 0; i < 16; i++) g2[15-i] = o2[1+i];
        check("t6_bits", 64'(g2), 64'(e2));
        check("t6_fs", 64'({fs2[1], fs2[2]}), 64'b10);
        check("t6_vld_last", 64'({vld2[16], vld2[17]}), 64'b10);
        check("t6_done", 64'({dn2[16], dn2[17], dn2[18]}), 64'b010);
        check("t6_dout_idle", 64'(o2[17]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
